neuron_mac_seq: RTL and testbench
=================================

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 Parameter N_TAPS, default 28; number of weight/input pairs per neuron slice.
REQ-002 Parameter AW, default 5; address width, N_TAPS <= 2^AW.
REQ-003 Parameter DW, default 16; signed two's-complement data width of weights, inputs, bias and result.
REQ-004 Parameter FRAC, default 8; fractional bits (Q8.8 at defaults).
REQ-005 Parameter ACC_W, default 40; accumulator width.
REQ-006 CLK  in  1  single clock; all state on rising edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 START  in  1  request one neuron evaluation; sampled only in IDLE.
REQ-009 BIAS  in  DW  signed bias, sampled on the edge that accepts START.
REQ-010 W_ADDR  out  AW  weight-BRAM address.
REQ-011 W_EN  out  1  weight-BRAM enable.
REQ-012 W_WE  out  1  weight-BRAM write enable; constant 0.
REQ-013 W_DO  in  DW  weight-BRAM read data, updated by the BRAM on the falling edge following the address.
REQ-014 X_ADDR  out  AW  input-buffer address; always equal to W_ADDR.
REQ-015 X_DO  in  DW  input-buffer read data, same timing as W_DO.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 DONE  out  1  one-cycle pulse; RESULT is valid.
REQ-018 RESULT  out  DW  saturated neuron output, held until the next DONE.

Function
REQ-019 States SHALL be IDLE, RUN, DRAIN and OUT; unused encodings SHALL return to IDLE.
REQ-020 IDLE: W_EN=0 and W_ADDR=0; START=1 at edge E0 SHALL load ACC = sign_extend(BIAS) << FRAC, set W_ADDR=0 and W_EN=1, and go to RUN.
REQ-021 RUN: W_ADDR SHALL increment by 1 per edge through N_TAPS-1; at each edge E(i+1), ACC SHALL add sign_extend(W_DO*X_DO) for address i (full 2*DW-bit signed product).
REQ-022 On the edge that leaves W_ADDR=N_TAPS-1, W_EN SHALL drop to 0 and the state SHALL go to DRAIN; the last product SHALL be accumulated on that edge (E(N_TAPS)).
REQ-023 DRAIN SHALL last one cycle; at the next edge, RESULT SHALL be loaded with ACC >>> FRAC (arithmetic shift), saturated to [-2^(DW-1), 2^(DW-1)-1], and the state SHALL go to OUT with DONE=1.
REQ-024 OUT SHALL last one cycle and then return to IDLE; DONE SHALL be high only in OUT. At defaults, DONE is high during the cycle after edge E29.
REQ-025 START while BUSY=1 SHALL be ignored, with no restart and no queuing; START held high through OUT SHALL be accepted on the first IDLE edge.
REQ-026 ACC SHALL NOT wrap for N_TAPS full-scale products plus bias; ACC_W >= 2*DW + ceil(log2(N_TAPS+1)).
REQ-027 RESULT SHALL NOT change except in the cycle in which DONE is asserted.

Reset
REQ-028 While RST_N=0: state=IDLE, ACC=0, W_ADDR=0, W_EN=0, W_WE=0, BUSY=0, DONE=0, RESULT=0, asynchronously.
REQ-029 Reset mid-operation SHALL abort with no DONE; after RST_N rises, the next START SHALL begin a clean evaluation from address 0.

Configuration
REQ-030 Macro NEURON_MAC_SEQ_RELU_EN: when defined, a negative saturated value SHALL be written to RESULT as 0; when undefined, RESULT SHALL be the signed saturated value. Timing SHALL be identical in both builds.

Verification
REQ-031 All W=0x0100, all X=0x0100, BIAS=0 -> RESULT=0x1C00 (28.0); DONE at the 29th edge after E0; W_ADDR sequence 0..27 observed, each address for exactly one cycle.
REQ-032 All W=0x7FFF, X=0x7FFF, BIAS=0x7FFF -> RESULT=0x7FFF (positive saturation); all W=0x8000, X=0x7FFF -> RESULT=0x8000 without the macro.
REQ-033 W=0x0100, X=0xFF00 (-1.0), BIAS=0 -> RESULT=0xE400 (-28.0) without NEURON_MAC_SEQ_RELU_EN, and 0x0000 with it.
REQ-034 START pulsed again at edge E10 -> no restart; exactly one DONE, with RESULT unchanged versus the case with no second pulse.
REQ-035 RST_N low at edge E15 -> all outputs 0 immediately and no DONE; a new START then reproduces the REQ-031 result exactly.
REQ-036 Two back-to-back evaluations, with START held high -> the second is accepted on the first IDLE edge; RESULT updates only on each DONE; W_WE=0 throughout.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Sequential multiply-accumulate neuron: streams N_TAPS weight/input pairs from BRAM, adds bias, saturates.
// Optional build macro NEURON_MAC_SEQ_RELU_EN clamps negative results to zero.
module neuron_mac_seq #(
    parameter int N_TAPS = 28,
    parameter int AW     = 5,
    parameter int DW     = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] bias,
    output logic        [AW-1:0] w_addr,
    output logic                 w_en,
    output logic                 w_we,
    input  logic signed [DW-1:0] w_do,
    output logic        [AW-1:0] x_addr,
    input  logic signed [DW-1:0] x_do,
    output logic                 busy,
    output logic                 done,
    output logic        [DW-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic        [AW-1:0]    LAST_ADDR = AW'(N_TAPS - 1);

    state_t                    state, state_next;
    logic signed [ACC_W-1:0]   acc;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   shifted;
    logic        [DW-1:0]      result_next;
    logic                      last_tap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_tap ? DRAIN : RUN;
            DRAIN:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == OUT);
        w_en = (state == RUN);
    end

    assign w_we     = 1'b0;
    assign x_addr   = w_addr;
    assign last_tap = (w_addr == LAST_ADDR);
    assign prod     = w_do * x_do;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias} <<< FRAC;
    assign shifted  = acc >>> FRAC;

    // Saturate the rescaled accumulator to the DW-bit output range.
    always_comb begin
        result_next = shifted[DW-1:0];
        if (shifted > SAT_MAX)
            result_next = {1'b0, {(DW-1){1'b1}}};
        else if (shifted < SAT_MIN)
            result_next = {1'b1, {(DW-1){1'b0}}};
`ifdef NEURON_MAC_SEQ_RELU_EN
        if (result_next[DW-1])
            result_next = '0;
`endif
    end

    // The product accumulated on each RUN edge belongs to the address presented one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            w_addr <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    w_addr <= '0;
                    if (start)
                        acc <= bias_ext;
                end
                RUN: begin
                    acc    <= acc + prod_ext;
                    w_addr <= last_tap ? '0 : w_addr + 1'b1;
                end
                DRAIN: begin
                    result <= result_next;
                end
                default: begin
                    w_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: BRAM model, arithmetic reference model, directed and random scenarios.
module tb_neuron_mac_seq;
    localparam int N_TAPS = 28;
    localparam int AW     = 5;
    localparam int DW     = 16;
    localparam int FRAC   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] bias = '0;
    logic signed [DW-1:0] w_do = '0;
    logic signed [DW-1:0] x_do = '0;
    logic        [AW-1:0] w_addr, x_addr;
    logic                 w_en, w_we, busy, done;
    logic        [DW-1:0] result;

    logic signed [DW-1:0] wmem [0:31];
    logic signed [DW-1:0] xmem [0:31];

    int total = 0;
    int bad   = 0;

    neuron_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .w_addr(w_addr), .w_en(w_en), .w_we(w_we), .w_do(w_do),
        .x_addr(x_addr), .x_do(x_do), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // BRAM read data follows the address on the falling edge.
    always @(negedge clk) begin
        if (w_en) begin
            w_do <= wmem[w_addr];
            x_do <= xmem[x_addr];
        end
    end

    function automatic logic [DW-1:0] model(input logic signed [DW-1:0] b);
        longint acc;
        acc = longint'(b) * (longint'(1) << FRAC);
        for (int i = 0; i < N_TAPS; i++)
            acc += longint'(wmem[i]) * longint'(xmem[i]);
        acc = acc >>> FRAC;
        if (acc > 32767)       acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef NEURON_MAC_SEQ_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[DW-1:0];
    endfunction

    task automatic fill(input logic [DW-1:0] wv, input logic [DW-1:0] xv);
        for (int i = 0; i < 32; i++) begin
            wmem[i] = wv;
            xmem[i] = xv;
        end
    endtask

    task automatic fill_random(input bit full_range);
        for (int i = 0; i < 32; i++) begin
            if (full_range) begin
                wmem[i] = DW'($urandom);
                xmem[i] = DW'($urandom);
            end else begin
                wmem[i] = DW'(int'($urandom_range(0, 1023)) - 512);
                xmem[i] = DW'(int'($urandom_range(0, 1023)) - 512);
            end
        end
    endtask

    // Runs one evaluation; optionally re-pulses start at edge pulse_at.
    task automatic do_eval(input logic signed [DW-1:0] b, input int pulse_at,
                           output int done_edge, output int nseen, output logic addr_ok,
                           output logic res_stable, output logic post_idle);
        logic [DW-1:0] res_before;
        int k;
        done_edge = -1; nseen = 0; addr_ok = 1'b1; res_stable = 1'b1;
        @(negedge clk);
        bias = b; start = 1'b1; res_before = result;
        @(posedge clk); #1;
        start = 1'b0; k = 0;
        if (w_en === 1'b1) begin
            if (w_addr !== AW'(0)) addr_ok = 1'b0;
            nseen++;
        end
        while (k < 100 && done_edge < 0) begin
            start = (k + 1 == pulse_at);
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) done_edge = k;
            else begin
                if (result !== res_before) res_stable = 1'b0;
                if (w_en === 1'b1) begin
                    if (w_addr !== AW'(nseen) || x_addr !== w_addr) addr_ok = 1'b0;
                    nseen++;
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        post_idle = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++; if (result !== '0) begin bad++; $display("[TB] FAIL reset_result got=%h want=0", result); end
        total++; if (w_addr !== '0) begin bad++; $display("[TB] FAIL reset_w_addr got=%h want=0", w_addr); end
        total++; if ({w_en, w_we, busy, done} !== 4'b0) begin bad++; $display("[TB] FAIL reset_ctrl got=%b want=0000", {w_en, w_we, busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int de, ns; logic aok, rst, pid;
        fill(16'h0100, 16'h0100);
        do_eval(16'sh0000, -1, de, ns, aok, rst, pid);
        total++; if (de !== 29) begin bad++; $display("[TB] FAIL basic_done_edge got=%0d want=29", de); end
        total++; if (result !== 16'h1C00) begin bad++; $display("[TB] FAIL basic_result got=%h want=1c00", result); end
        total++; if (ns !== N_TAPS) begin bad++; $display("[TB] FAIL basic_addr_count got=%0d want=%0d", ns, N_TAPS); end
        total++; if (aok !== 1'b1) begin bad++; $display("[TB] FAIL basic_addr_seq got=%b want=1", aok); end
        total++; if (rst !== 1'b1) begin bad++; $display("[TB] FAIL basic_result_stable got=%b want=1", rst); end
        total++; if (pid !== 1'b1) begin bad++; $display("[TB] FAIL basic_done_pulse got=%b want=1", pid); end
    endtask

    task automatic test_saturation;
        int de, ns; logic aok, rst, pid;
        logic [DW-1:0] exp_neg;
        fill(16'h7FFF, 16'h7FFF);
        do_eval(16'sh7FFF, -1, de, ns, aok, rst, pid);
        total++; if (result !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_pos got=%h want=7fff", result); end
`ifdef NEURON_MAC_SEQ_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'h8000;
`endif
        fill(16'h8000, 16'h7FFF);
        do_eval(16'sh0000, -1, de, ns, aok, rst, pid);
        total++; if (result !== exp_neg) begin bad++; $display("[TB] FAIL sat_neg got=%h want=%h", result, exp_neg); end
    endtask

    task automatic test_negative;
        int de, ns; logic aok, rst, pid;
        logic [DW-1:0] exp_v;
`ifdef NEURON_MAC_SEQ_RELU_EN
        exp_v = 16'h0000;
`else
        exp_v = 16'hE400;
`endif
        fill(16'h0100, 16'hFF00);
        do_eval(16'sh0000, -1, de, ns, aok, rst, pid);
        total++; if (result !== exp_v) begin bad++; $display("[TB] FAIL negative got=%h want=%h", result, exp_v); end
    endtask

    task automatic test_random;
        int de, ns; logic aok, rst, pid;
        logic signed [DW-1:0] b;
        logic [DW-1:0] exp_v;
        for (int it = 0; it < 6; it++) begin
            fill_random(it >= 4);
            b = DW'($urandom);
            exp_v = model(b);
            do_eval(b, -1, de, ns, aok, rst, pid);
            total++; if (result !== exp_v) begin bad++; $display("[TB] FAIL random_%0d got=%h want=%h", it, result, exp_v); end
            total++; if (de !== 29) begin bad++; $display("[TB] FAIL random_%0d_latency got=%0d want=29", it, de); end
        end
    endtask

    task automatic test_start_while_busy;
        int de, ns; logic aok, rst, pid;
        logic [DW-1:0] exp_v;
        int extra_done;
        fill_random(1'b0);
        exp_v = model(16'sh0123);
        do_eval(16'sh0123, 10, de, ns, aok, rst, pid);
        total++; if (de !== 29) begin bad++; $display("[TB] FAIL busy_start_latency got=%0d want=29", de); end
        total++; if (result !== exp_v) begin bad++; $display("[TB] FAIL busy_start_result got=%h want=%h", result, exp_v); end
        total++; if (ns !== N_TAPS || aok !== 1'b1) begin bad++; $display("[TB] FAIL busy_start_addr got=%0d/%b want=%0d/1", ns, aok, N_TAPS); end
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        total++; if (pid !== 1'b1 || extra_done !== 0) begin bad++; $display("[TB] FAIL busy_start_restart got=%0d want=0", extra_done); end
    endtask

    task automatic test_reset_mid;
        int de, ns; logic aok, rst, pid;
        int done_cnt;
        fill(16'h0100, 16'h0100);
        @(negedge clk);
        bias = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        total++; if ({busy, w_en, done, w_we} !== 4'b0 || w_addr !== '0 || result !== '0) begin
            bad++; $display("[TB] FAIL midreset_outputs got=%b/%h/%h want=0000/0/0", {busy, w_en, done, w_we}, w_addr, result);
        end
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        total++; if (done_cnt !== 0) begin bad++; $display("[TB] FAIL midreset_no_done got=%0d want=0", done_cnt); end
        do_eval(16'sh0000, -1, de, ns, aok, rst, pid);
        total++; if (result !== 16'h1C00 || de !== 29 || aok !== 1'b1) begin
            bad++; $display("[TB] FAIL midreset_rerun got=%h@%0d want=1c00@29", result, de);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_a, exp_b, hold_v;
        int k, ndone, e1, e2;
        logic stable, we_ok;
        fill_random(1'b0);
        exp_a = model(16'sh0040);
        e1 = -1; e2 = -1; ndone = 0; stable = 1'b1; we_ok = 1'b1; exp_b = '0;
        @(negedge clk);
        bias = 16'sh0040; start = 1'b1; hold_v = result;
        @(posedge clk); #1;
        k = 0;
        while (k < 200 && ndone < 2) begin
            @(posedge clk); #1;
            k++;
            if (w_we !== 1'b0) we_ok = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    e1 = k;
                    total++; if (result !== exp_a) begin bad++; $display("[TB] FAIL b2b_first got=%h want=%h", result, exp_a); end
                    hold_v = result;
                    fill_random(1'b0);
                    bias = -16'sh0100;
                    exp_b = model(-16'sh0100);
                end else begin
                    e2 = k;
                    total++; if (result !== exp_b) begin bad++; $display("[TB] FAIL b2b_second got=%h want=%h", result, exp_b); end
                end
            end else if (result !== hold_v) stable = 1'b0;
        end
        start = 1'b0;
        total++; if (e1 !== 29 || e2 !== 60) begin bad++; $display("[TB] FAIL b2b_timing got=%0d,%0d want=29,60", e1, e2); end
        total++; if (stable !== 1'b1) begin bad++; $display("[TB] FAIL b2b_result_stable got=%b want=1", stable); end
        total++; if (we_ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_w_we got=%b want=1", we_ok); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_negative;
        test_random;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
